multi_debouncer: RTL and testbench

Multi-channel, parametrised debouncer for Basys3 push-buttons and switches. Each channel has a two-flop synchroniser, a saturating hysteresis counter, a stable level output, one-cycle press and release pulses, and an optional auto-repeat pulse train while the button is held. It sits between the raw board pins and the stopwatch control logic, replacing the single-channel press-only debouncer.

---
 rtl/multi_debouncer.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_debouncer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//
// Multi-channel push-button / switch debouncer. Every channel owns a two-flop
// synchroniser, a saturating up/down hysteresis counter, a registered stable
// level, one-cycle rise/fall pulses and an auto-repeat pulse generator that
// fires while the debounced level stays high.
//
// Parameters
//   CHANNELS       number of independent channels
//   COUNTER_BITS   hysteresis counter width (MAX = 2^COUNTER_BITS - 1, >= 2)
//   REPEAT_BITS    width of each channel's auto-repeat timer
//   REPEAT_DELAY   cycles from rise to the first repeat pulse (>= 2)
//   REPEAT_PERIOD  cycles between later repeat pulses (>= 2)
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   repeat_en       global auto-repeat enable (level)
//   input_unstable  raw asynchronous inputs, one bit per channel
//   output_stable   debounced level per channel
//   rise_pulse      one-cycle pulse on a debounced 0->1 transition
//   fall_pulse      one-cycle pulse on a debounced 1->0 transition
//   repeat_pulse    one-cycle auto-repeat pulses while the level is held
// -----------------------------------------------------------------------------
module multi_debouncer #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned COUNTER_BITS  = 7,
    parameter int unsigned REPEAT_BITS   = 24,
    parameter int unsigned REPEAT_DELAY  = 5000000,
    parameter int unsigned REPEAT_PERIOD = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                repeat_en,
    input  logic [CHANNELS-1:0] input_unstable,
    output logic [CHANNELS-1:0] output_stable,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    // Counter landmarks: the level flips on the edge that moves the counter
    // onto one of its rails, so the comparisons are against MAX-1 and 1.
    localparam logic [COUNTER_BITS-1:0] CNT_MAX      = {COUNTER_BITS{1'b1}};
    localparam logic [COUNTER_BITS-1:0] CNT_ONE      = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] CNT_NEAR_MAX = CNT_MAX - CNT_ONE;

    // Terminal timer values; the timer counts 0..N-1 so a pulse lands N
    // edges after the timer was cleared.
    localparam logic [REPEAT_BITS-1:0] TMR_ONE     = REPEAT_BITS'(1);
    localparam logic [REPEAT_BITS-1:0] DELAY_LAST  = REPEAT_BITS'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_BITS-1:0] PERIOD_LAST = REPEAT_BITS'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for all channels; only sync2_q feeds the logic.
    // -------------------------------------------------------------------------
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    always_ff @(posedge clk or posedge reset) begin : sync_reg
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= input_unstable;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel debounce and auto-repeat
    // -------------------------------------------------------------------------
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan

        logic [COUNTER_BITS-1:0] cnt_q;
        logic [COUNTER_BITS-1:0] cnt_d;
        logic                    stable_q;
        logic                    stable_d;
        logic                    rise_q;
        logic                    rise_d;
        logic                    fall_q;
        logic                    fall_d;
        logic                    set_c;
        logic                    clr_c;

        rpt_state_e              state_q;
        rpt_state_e              state_d;
        logic [REPEAT_BITS-1:0]  timer_q;
        logic [REPEAT_BITS-1:0]  timer_d;
        logic                    rpt_q;
        logic                    rpt_d;

        // Saturating counter: climbs while the synchronised input is high,
        // falls while it is low, never wraps.
        always_comb begin : cnt_next
            cnt_d = cnt_q;
            if (sync2_q[ch] && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (!sync2_q[ch] && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        // Level events: only the step onto a rail can change the level,
        // which is what gives the hysteresis between 0 and MAX.
        assign set_c = sync2_q[ch] && (cnt_q == CNT_NEAR_MAX) && !stable_q;
        assign clr_c = !sync2_q[ch] && (cnt_q == CNT_ONE) && stable_q;

        // Level and edge-pulse next values.
        always_comb begin : level_next
            stable_d = stable_q;
            rise_d   = set_c;
            fall_d   = clr_c;
            if (set_c) begin
                stable_d = 1'b1;
            end else if (clr_c) begin
                stable_d = 1'b0;
            end
        end

        // Counter, level and edge-pulse registers.
        always_ff @(posedge clk or posedge reset) begin : level_reg
            if (reset) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
            end
        end

        // Repeat FSM state register (timer and registered pulse ride along).
        always_ff @(posedge clk or posedge reset) begin : rpt_state_reg
            if (reset) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                rpt_q   <= rpt_d;
            end
        end

        // Repeat FSM next state. A fall always wins; a disabled repeat parks
        // the FSM in WAIT with a cleared timer so re-enabling restarts the
        // full initial delay.
        always_comb begin : rpt_next
            state_d = state_q;
            timer_d = timer_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (set_c) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end
                end
                ST_WAIT: begin
                    if (clr_c) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (!repeat_en) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end else if (timer_q == DELAY_LAST) begin
                        state_d = ST_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (clr_c) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (!repeat_en) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end else if (timer_q == PERIOD_LAST) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // Repeat FSM output: pulse when the running timer expires, unless
        // repeat is disabled or a fall lands on the same edge.
        always_comb begin : rpt_out
            rpt_d = 1'b0;
            if (repeat_en && !clr_c) begin
                if ((state_q == ST_WAIT) && (timer_q == DELAY_LAST)) begin
                    rpt_d = 1'b1;
                end else if ((state_q == ST_REPEAT) && (timer_q == PERIOD_LAST)) begin
                    rpt_d = 1'b1;
                end
            end
        end

        assign output_stable[ch] = stable_q;
        assign rise_pulse[ch]    = rise_q;
        assign fall_pulse[ch]    = fall_q;
        assign repeat_pulse[ch]  = rpt_q;

    end : g_chan

endmodule : multi_debouncer

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
//
// Directed bench for multi_debouncer with CHANNELS=4, COUNTER_BITS=3 (MAX=7),
// REPEAT_DELAY=20, REPEAT_PERIOD=5. Inputs change 1 ns after a rising edge, so
// a value written after edge e-1 is "held before edge e"; outputs are sampled
// at the same point and reflect the state after the edge just taken.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;

    localparam int unsigned CHANNELS      = 4;
    localparam int unsigned COUNTER_BITS  = 3;
    localparam int unsigned REPEAT_BITS   = 8;
    localparam int unsigned REPEAT_DELAY  = 20;
    localparam int unsigned REPEAT_PERIOD = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                repeat_en;
    logic [CHANNELS-1:0] input_unstable;
    logic [CHANNELS-1:0] output_stable;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic [CHANNELS-1:0] repeat_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    multi_debouncer #(
        .CHANNELS      (CHANNELS),
        .COUNTER_BITS  (COUNTER_BITS),
        .REPEAT_BITS   (REPEAT_BITS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .repeat_en      (repeat_en),
        .input_unstable (input_unstable),
        .output_stable  (output_stable),
        .rise_pulse     (rise_pulse),
        .fall_pulse     (fall_pulse),
        .repeat_pulse   (repeat_pulse)
    );

    always #5 clk = ~clk;

    // One segment of constant inputs with constant expected outputs.
    typedef struct {
        logic [3:0]  in;
        logic        en;
        int unsigned edges;
        logic [3:0]  st;
        logic [3:0]  ri;
        logic [3:0]  fa;
        logic [3:0]  rp;
    } seg_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] on_if(input bit c, input logic [3:0] v);
        return c ? v : 4'b0000;
    endfunction

    task automatic check(input string name, input int e,
                         input logic [3:0] es, input logic [3:0] er,
                         input logic [3:0] ef, input logic [3:0] ep);
        tests_run++;
        if (output_stable !== es || rise_pulse !== er ||
            fall_pulse !== ef || repeat_pulse !== ep) begin
            tests_failed++;
            $display("FAIL %s edge %0d: got st=%b ri=%b fa=%b rp=%b, want st=%b ri=%b fa=%b rp=%b",
                     name, e, output_stable, rise_pulse, fall_pulse, repeat_pulse,
                     es, er, ef, ep);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    seg_t tbl[6];

    initial begin
        int e;
        int rises;
        int falls;

        // Clean press at edge 0, release at edge 40 on ch0 (repeat disabled).
        tbl[0] = '{4'b0001, 1'b0,  8, 4'b0000, 4'b0000, 4'b0000, 4'b0000}; // 0..7
        tbl[1] = '{4'b0001, 1'b0,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000}; // 8
        tbl[2] = '{4'b0001, 1'b0, 31, 4'b0001, 4'b0000, 4'b0000, 4'b0000}; // 9..39
        tbl[3] = '{4'b0000, 1'b0,  8, 4'b0001, 4'b0000, 4'b0000, 4'b0000}; // 40..47
        tbl[4] = '{4'b0000, 1'b0,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000}; // 48
        tbl[5] = '{4'b0000, 1'b0,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000}; // 49..53

        // ---------------- reset state ----------------
        reset          = 1'b1;
        repeat_en      = 1'b0;
        input_unstable = 4'b0000;
        repeat (3) step();
        check("reset_state", -1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;

        // ---------------- 1: clean press/release (table) ----------------
        e = 0;
        foreach (tbl[s]) begin
            input_unstable = tbl[s].in;
            repeat_en      = tbl[s].en;
            for (int i = 0; i < int'(tbl[s].edges); i++) begin
                step();
                check("t1_clean", e, tbl[s].st, tbl[s].ri, tbl[s].fa, tbl[s].rp);
                e++;
            end
        end

        // ---------------- 2: bounce on ch1 ----------------
        rises = 0;
        falls = 0;
        for (int k = 0; k < 60; k++) begin
            input_unstable = (k < 30 && (k % 3) == 2) ? 4'b0000 : 4'b0010;
            step();
            if (rise_pulse[1]) rises++;
            if (fall_pulse[1]) falls++;
        end
        check_int("t2_rise_count", rises, 1);
        check_int("t2_fall_count", falls, 0);
        check("t2_held", 59, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        input_unstable = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            step();
            if (fall_pulse[1]) falls++;
        end
        check_int("t2_release_fall", falls, 1);
        check("t2_released", 11, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // ---------------- 3: auto-repeat on ch2, rise at R=8 ----------------
        repeat_en = 1'b1;
        for (int k = 0; k < 80; k++) begin
            input_unstable = (k < 58) ? 4'b0100 : 4'b0000;
            step();
            check("t3_repeat", k,
                  on_if(k >= 8 && k < 66, 4'b0100),
                  on_if(k == 8, 4'b0100),
                  on_if(k == 66, 4'b0100),
                  on_if(k >= 28 && k <= 63 && ((k - 28) % 5) == 0, 4'b0100));
        end

        // ---- 3b: repeat_en low for edges R+22..R+30, fall lands on a due pulse ----
        for (int k = 0; k < 80; k++) begin
            input_unstable = (k < 60) ? 4'b0100 : 4'b0000;
            repeat_en      = (k >= 30 && k <= 38) ? 1'b0 : 1'b1;
            step();
            check("t3_en_gap", k,
                  on_if(k >= 8 && k < 68, 4'b0100),
                  on_if(k == 8, 4'b0100),
                  on_if(k == 68, 4'b0100),
                  on_if(k == 28 || k == 58 || k == 63, 4'b0100));
        end

        // ---------------- 4: fall at R+25 collides with repeat ----------------
        repeat_en = 1'b1;
        for (int k = 0; k < 46; k++) begin
            input_unstable = (k < 25) ? 4'b0100 : 4'b0000;
            step();
            check("t4_collide", k,
                  on_if(k >= 8 && k < 33, 4'b0100),
                  on_if(k == 8, 4'b0100),
                  on_if(k == 33, 4'b0100),
                  on_if(k == 28, 4'b0100));
        end

        // ---------------- 5: all channels together ----------------
        repeat_en      = 1'b0;
        input_unstable = 4'b1111;
        for (int k = 0; k < 13; k++) begin
            step();
            check("t5_simul", k,
                  on_if(k >= 8, 4'b1111),
                  on_if(k == 8, 4'b1111),
                  4'b0000, 4'b0000);
        end

        // ---------------- 6: async reset mid-hold on ch3 ----------------
        input_unstable = 4'b1000;
        for (int k = 0; k < 9; k++) begin
            step();
            check("t6_pre", k,
                  (k < 8) ? 4'b1111 : 4'b1000,
                  4'b0000,
                  on_if(k == 8, 4'b0111),
                  4'b0000);
        end
        // fall pulses are high now; reset between edges must clear them
        #2 reset = 1'b1;
        #1 check("t6_in_reset", -1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #2 reset = 1'b0;
        #1 check("t6_after_reset", -1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 12; k++) begin
            step();
            check("t6_rehold", k,
                  on_if(k >= 8, 4'b1000),
                  on_if(k == 8, 4'b1000),
                  4'b0000, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_multi_debouncer
